// File: rtl/isa_pkg.sv
// Shared RV32I encoding definitions for the instruction encoder.
// Holds the supported opcode constants, the instruction format enum,
// the encoder FSM state encoding and a request bundle type.
package isa_pkg;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {FMT_I, FMT_S, FMT_B, FMT_BAD} fmt_e;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;

    // Decoded instruction fields as presented on the request port.
    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [31:0] imm;
    } req_t;

endpackage

// File: rtl/imm_pack.sv
// Immediate placement for the supported RV32I formats (combinational).
// Ports:
//   opcode   - 7-bit major opcode
//   imm      - signed 32-bit immediate
//   fmt      - instruction format derived from opcode (FMT_BAD if unsupported)
//   imm_bits - 32-bit word holding only the immediate bits at their final
//              positions; all register/funct/opcode positions are zero
//   illegal  - unsupported opcode or immediate out of range for the format
module imm_pack
    import isa_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [31:0] imm,
    output fmt_e        fmt,
    output logic [31:0] imm_bits,
    output logic        illegal
);

    logic i_ok;
    logic b_ok;

    // Sign-extension checks: the discarded upper bits must all copy the sign.
    assign i_ok = (imm[31:11] == '0) || (imm[31:11] == '1);
    // Branch offsets are 13-bit, half-word aligned.
    assign b_ok = ((imm[31:12] == '0) || (imm[31:12] == '1)) && !imm[0];

    always_comb begin
        unique case (opcode)
            OPC_OP_IMM, OPC_LOAD: fmt = FMT_I;
            OPC_STORE:            fmt = FMT_S;
            OPC_BRANCH:           fmt = FMT_B;
            default:              fmt = FMT_BAD;
        endcase
    end

    always_comb begin
        imm_bits = '0;
        illegal  = 1'b1;
        unique case (fmt)
            FMT_I: begin
                imm_bits = {imm[11:0], 20'b0};
                illegal  = !i_ok;
            end
            FMT_S: begin
                imm_bits = {imm[11:5], 13'b0, imm[4:0], 7'b0};
                illegal  = !i_ok;
            end
            FMT_B: begin
                imm_bits = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
                illegal  = !b_ok;
            end
            default: begin
                imm_bits = '0;
                illegal  = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streaming RV32I instruction encoder.
// Accepts decoded instruction requests (valid/ready), encodes them into
// 32-bit machine words and writes them to consecutive word addresses of
// instruction memory through a stallable write port.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   start/base_addr/length- program start pulse, first address, request count
//   in_valid/in_ready     - request handshake
//   opcode..imm           - request fields
//   mem_we/mem_addr/mem_wdata/mem_ready - memory write port
//   busy/done/err/err_count - status
module instr_encoder
    import isa_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  length,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6:0]            opcode,
    input  logic [4:0]            rd,
    input  logic [4:0]            rs1,
    input  logic [4:0]            rs2,
    input  logic [2:0]            funct3,
    input  logic [31:0]           imm,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [LEN_WIDTH-1:0]  err_count
);

    state_e                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;     // address of the next legal write
    logic [LEN_WIDTH-1:0]  remaining;  // requests still to accept
    req_t                  req;
    fmt_e                  fmt;
    logic [31:0]           imm_bits;
    logic                  illegal;
    logic [31:0]           field_bits;
    logic [31:0]           word;
    logic                  accept;
    logic                  last_accept;

    assign req = '{opcode: opcode, rd: rd, rs1: rs1, rs2: rs2, funct3: funct3, imm: imm};

    imm_pack u_imm_pack (
        .opcode   (req.opcode),
        .imm      (req.imm),
        .fmt      (fmt),
        .imm_bits (imm_bits),
        .illegal  (illegal)
    );

    // I-type carries rd; S/B-type carry rs2 instead and use the rd slot for immediate.
    assign field_bits = (fmt == FMT_I)
                      ? {12'b0, req.rs1, req.funct3, req.rd, req.opcode}
                      : {7'b0, req.rs2, req.rs1, req.funct3, 5'b0, req.opcode};
    assign word = imm_bits | field_bits;

    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (remaining == LEN_WIDTH'(1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (start) state_nxt = (length == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (last_accept) state_nxt = ST_DRAIN;
            ST_DRAIN: if (!mem_we || mem_ready) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs. A new request may be taken while the held write retires.
    always_comb begin
        in_ready = (state == ST_RUN) && (!mem_we || mem_ready);
        busy     = (state != ST_IDLE);
        done     = (state == ST_DONE);
    end

    // Counters and output register
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q    <= '0;
            remaining <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            err       <= 1'b0;
            err_count <= '0;
        end else begin
            err <= 1'b0;
            if (state == ST_IDLE && start && length != '0) begin
                addr_q    <= base_addr & ~ADDR_WIDTH'(3);
                remaining <= length;
                err_count <= '0;
            end
            if (mem_we && mem_ready) mem_we <= 1'b0;
            // A legal accept below overrides the retire above (back-to-back).
            if (accept) begin
                remaining <= remaining - LEN_WIDTH'(1);
                if (illegal) begin
                    err <= 1'b1;
                    if (err_count != '1) err_count <= err_count + LEN_WIDTH'(1);
                end else begin
                    mem_we    <= 1'b1;
                    mem_addr  <= addr_q;
                    mem_wdata <= word;
                    addr_q    <= addr_q + ADDR_WIDTH'(4);
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [31:0] base_addr;
    logic [15:0] length;
    logic        in_valid, in_ready;
    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ready, busy, done, err;
    logic [15:0] err_count;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_WIDTH(32), .LEN_WIDTH(16)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .length(length),
        .in_valid(in_valid), .in_ready(in_ready), .opcode(opcode), .rd(rd), .rs1(rs1),
        .rs2(rs2), .funct3(funct3), .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy), .done(done), .err(err),
        .err_count(err_count)
    );

    typedef struct {
        logic [6:0]  op;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [31:0] imm;
    } treq_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          c;
    } wr_t;

    treq_t       reqs[$];
    wr_t         obs_q[$];
    logic [31:0] exp_a[$];
    logic [31:0] exp_d[$];
    int          n_assert = 0, n_fail = 0, cyc = 0;
    int          err_seen = 0, done_seen = 0;
    bit          rand_ready = 0;

    // Observer: writes retire, err and done pulses, sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            if (mem_we && mem_ready) obs_q.push_back('{mem_addr, mem_wdata, cyc});
            if (err)  err_seen++;
            if (done) done_seen++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Reference model: range checks on the signed value, fields by arithmetic.
    function automatic bit mdl_legal(treq_t r);
        int v = r.imm;
        case (r.op)
            7'h13, 7'h03, 7'h23: return (v >= -2048) && (v <= 2047);
            7'h63:               return (v >= -4096) && (v <= 4095) && (v % 2 == 0);
            default:             return 0;
        endcase
    endfunction

    function automatic logic [31:0] mdl_word(treq_t r);
        logic [31:0] u = r.imm;
        logic [31:0] f = (32'(r.rs1) << 15) | (32'(r.f3) << 12) | 32'(r.op);
        case (r.op)
            7'h13, 7'h03: return ((u % 4096) << 20) | f | (32'(r.rd) << 7);
            7'h23: return (((u / 32) % 128) << 25) | (32'(r.rs2) << 20) | f | ((u % 32) << 7);
            default: return (((u / 4096) % 2) << 31) | (((u / 32) % 64) << 25) |
                            (32'(r.rs2) << 20) | f | (((u / 2) % 16) << 8) |
                            (((u / 2048) % 2) << 7);
        endcase
    endfunction

    function automatic treq_t mk(logic [6:0] op, logic [4:0] rd_i, logic [4:0] rs1_i,
                                 logic [4:0] rs2_i, logic [2:0] f3, logic [31:0] im);
        treq_t r;
        r.op = op; r.rd = rd_i; r.rs1 = rs1_i; r.rs2 = rs2_i; r.f3 = f3; r.imm = im;
        return r;
    endfunction

    // Caller is always at posedge+1 on entry and exit.
    task automatic send(input treq_t r);
        bit acc = 0;
        opcode = r.op; rd = r.rd; rs1 = r.rs1; rs2 = r.rs2; funct3 = r.f3; imm = r.imm;
        in_valid = 1'b1;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            if (rand_ready) mem_ready = 1'($urandom_range(0, 1));
        end
        in_valid = 1'b0;
        chk("handshake", 32'(acc), 32'd1);
    endtask

    task automatic wait_idle();
        bit fin = 0;
        for (int k = 0; k < 200 && !fin; k++) begin
            @(negedge clk);
            fin = !busy;
            @(posedge clk); #1;
            if (rand_ready) mem_ready = 1'($urandom_range(0, 1));
        end
        chk("idle_timeout", 32'(fin), 32'd1);
    endtask

    // Run the program in reqs and compare against the model.
    task automatic run_prog(input logic [31:0] base);
        logic [31:0] a = base & 32'hFFFF_FFFC;
        int          e_err = 0;
        exp_a.delete(); exp_d.delete(); obs_q.delete();
        foreach (reqs[i]) begin
            if (mdl_legal(reqs[i])) begin
                exp_a.push_back(a); exp_d.push_back(mdl_word(reqs[i])); a = a + 4;
            end else e_err++;
        end
        err_seen = 0; done_seen = 0;
        start = 1'b1; base_addr = base; length = 16'(reqs.size());
        @(posedge clk); #1;
        start = 1'b0;
        foreach (reqs[i]) send(reqs[i]);
        wait_idle();
        chk("wr_count", 32'(obs_q.size()), 32'(exp_a.size()));
        for (int i = 0; i < obs_q.size() && i < exp_a.size(); i++) begin
            chk("wr_addr", obs_q[i].a, exp_a[i]);
            chk("wr_data", obs_q[i].d, exp_d[i]);
        end
        chk("err_pulses", 32'(err_seen), 32'(e_err));
        if (reqs.size() > 0) chk("err_count", 32'(err_count), 32'(e_err));
        chk("done_pulses", 32'(done_seen), 32'd1);
    endtask

    function automatic treq_t rnd_req();
        treq_t   r;
        int      sel = $urandom_range(0, 4);
        int      m   = $urandom_range(0, 3);
        int      b[11] = '{2047, 2048, -2048, -2049, 4095, 4094, 4096, -4096, -4098, 1, 0};
        r.op  = (sel == 0) ? 7'h13 : (sel == 1) ? 7'h03 : (sel == 2) ? 7'h23 :
                (sel == 3) ? 7'h63 : 7'h33;
        r.rd  = 5'($urandom); r.rs1 = 5'($urandom); r.rs2 = 5'($urandom); r.f3 = 3'($urandom);
        case (m)
            0:       r.imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            1:       r.imm = $urandom();
            2:       r.imm = b[$urandom_range(0, 10)];
            default: r.imm = (32'($urandom_range(0, 4095)) - 32'd2048) * 2;
        endcase
        return r;
    endfunction

    initial begin
        logic [31:0] sa, sd;
        reset = 1'b1; start = 1'b0; base_addr = '0; length = '0; in_valid = 1'b0;
        opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; imm = '0; mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0); chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_busy", 32'(busy), 0);         chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);           chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);    chk("rst_err_count", 32'(err_count), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Single addi
        reqs = '{mk(7'h13, 1, 0, 0, 0, 5)};
        run_prog(32'h100);
        if (obs_q.size() == 1) begin
            chk("t1_addr", obs_q[0].a, 32'h100); chk("t1_data", obs_q[0].d, 32'h0050_0093);
        end

        // lw / sw / beq back-to-back
        reqs = '{mk(7'h03, 2, 1, 0, 2, -4), mk(7'h23, 0, 1, 2, 2, 8), mk(7'h63, 0, 1, 2, 0, 16)};
        run_prog(32'h100);
        if (obs_q.size() == 3) begin
            chk("t2_d0", obs_q[0].d, 32'hFFC0_A103); chk("t2_d1", obs_q[1].d, 32'h0020_A423);
            chk("t2_d2", obs_q[2].d, 32'h0020_8863); chk("t2_a2", obs_q[2].a, 32'h108);
            chk("t2_b2b_1", 32'(obs_q[1].c - obs_q[0].c), 1);
            chk("t2_b2b_2", 32'(obs_q[2].c - obs_q[1].c), 1);
        end

        // Stall: write held for 3 cycles, start while busy ignored
        obs_q.delete(); done_seen = 0;
        start = 1'b1; base_addr = 32'h200; length = 16'd2;
        @(posedge clk); #1;
        start = 1'b0;
        send(mk(7'h13, 3, 4, 0, 1, 100));
        mem_ready = 1'b0;
        opcode = 7'h13; rd = 5; rs1 = 6; rs2 = 0; funct3 = 0; imm = 32'hFFFF_F800;
        in_valid = 1'b1;
        start = 1'b1; base_addr = 32'h500; length = 16'd5;
        @(negedge clk);
        sa = mem_addr; sd = mem_data_exp();
        chk("st_addr0", mem_addr, 32'h200); chk("st_data0", mem_wdata, sd);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            chk("st_we", 32'(mem_we), 1); chk("st_addr", mem_addr, sa);
            chk("st_data", mem_wdata, sd); chk("st_in_ready", 32'(in_ready), 0);
            @(posedge clk); #1;
            start = 1'b0;
        end
        mem_ready = 1'b1;
        @(negedge clk);
        chk("st_release_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("st_addr1", mem_addr, 32'h204);
        chk("st_data1", mem_wdata, mdl_word(mk(7'h13, 5, 6, 0, 0, 32'hFFFF_F800)));
        @(posedge clk); #1;
        wait_idle();
        chk("st_wr_count", 32'(obs_q.size()), 2); chk("st_done", 32'(done_seen), 1);

        // Illegal requests
        reqs = '{mk(7'h13, 1, 0, 0, 0, 2048), mk(7'h63, 0, 1, 2, 0, 3), mk(7'h33, 1, 2, 3, 0, 0)};
        run_prog(32'h100);
        chk("ill_err_count", 32'(err_count), 3);
        chk("ill_no_writes", 32'(obs_q.size()), 0);

        // Address wrap
        reqs = '{mk(7'h13, 1, 0, 0, 0, 1), mk(7'h13, 2, 0, 0, 0, 2)};
        run_prog(32'hFFFF_FFFC);
        if (obs_q.size() == 2) begin
            chk("wrap_a0", obs_q[0].a, 32'hFFFF_FFFC); chk("wrap_a1", obs_q[1].a, 32'h0);
        end

        // Zero-length program still signals done
        reqs.delete();
        run_prog(32'h40);

        // Reset while draining
        obs_q.delete(); done_seen = 0; mem_ready = 1'b0;
        start = 1'b1; base_addr = 32'h300; length = 16'd1;
        @(posedge clk); #1;
        start = 1'b0;
        send(mk(7'h13, 1, 1, 0, 0, 7));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; mem_ready = 1'b1;
        @(negedge clk);
        chk("rd_busy", 32'(busy), 0); chk("rd_mem_we", 32'(mem_we), 0);
        repeat (5) @(posedge clk);
        #1;
        chk("rd_no_done", 32'(done_seen), 0); chk("rd_no_write", 32'(obs_q.size()), 0);
        reqs = '{mk(7'h13, 1, 0, 0, 0, 5)};
        run_prog(32'h100);

        // Random programs with random memory back-pressure
        rand_ready = 1;
        for (int p = 0; p < 8; p++) begin
            reqs.delete();
            for (int i = 0; i < $urandom_range(0, 8); i++) reqs.push_back(rnd_req());
            run_prog($urandom());
        end
        rand_ready = 0; mem_ready = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Expected word for the first stall-test request.
    function automatic logic [31:0] mem_data_exp();
        return mdl_word(mk(7'h13, 3, 4, 0, 1, 100));
    endfunction

    initial begin
        #900000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Turns decoded instruction fields plus a signed 32-bit immediate into 32-bit RV32I machine words. Streams them into instruction memory at consecutive word addresses.
- Used by the program loader and by self-test benches to build programs for the core.
- Supports the same four opcode classes the core decodes: OP-IMM, LOAD, STORE, BRANCH.
- Handles valid/ready on the input side and a stallable write port on the memory side.

Parameters:
- ADDR_WIDTH, 32, width of the memory byte address and of the address counter.
- LEN_WIDTH, 16, width of the program-length counter.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a program; ignored unless the block is in IDLE.
- base_addr  in  ADDR_WIDTH  first write address; sampled on start; must be 4-byte aligned, bits [1:0] are forced to 0.
- length  in  LEN_WIDTH  number of requests in the program; sampled on start.
- in_valid  in  1  request valid.
- in_ready  out  1  request accepted when in_valid and in_ready are both high.
- opcode  in  7  must be 0010011, 0000011, 0100011 or 1100011.
- rd, rs1, rs2  in  5 each  register fields.
- funct3  in  3  function field.
- imm  in  32  signed immediate.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_WIDTH  write byte address.
- mem_wdata  out  32  encoded instruction.
- mem_ready  in  1  memory accepts the write when mem_we and mem_ready are both high.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the program has finished.
- err  out  1  one-cycle pulse for a rejected request.
- err_count  out  LEN_WIDTH  count of rejected requests in the current program; saturates at all-ones.

Behaviour:
- Reset values: state IDLE; in_ready, mem_we, busy, done, err all 0; mem_addr, mem_wdata, err_count, internal counters all 0.
- State machine:
  - IDLE: on start with length=0, go to DONE. On start with length>0, load addr=base_addr, remaining=length, clear err_count, go to RUN.
  - RUN: in_ready = !mem_we || mem_ready. On the accepting handshake, remaining decrements. When the last request has been accepted, go to DRAIN.
  - DRAIN: wait until mem_we==0 or the pending write completes with mem_ready=1, then go to DONE.
  - DONE: done=1 for exactly one cycle, then go to IDLE.
- Encoding, registered with 1 cycle from accept to mem_we:
  - OP-IMM and LOAD (I-type): {imm[11:0], rs1, funct3, rd, opcode}.
  - STORE (S-type): {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
  - BRANCH (B-type): {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
- Immediate legality:
  - I and S types: imm[31:11] must be all zeros or all ones.
  - B type: imm[31:12] must be all zeros or all ones, and imm[0] must be 0.
- Rejected requests (illegal immediate or unsupported opcode):
  - The request is still accepted and still decrements remaining.
  - No write is issued and the address does not advance.
  - err pulses 1 cycle after the handshake; err_count increments.
- Output register: mem_addr, mem_wdata and mem_we hold stable while mem_we=1 and mem_ready=0.
- Address advance: mem_addr for the next write = previous + 4, wrapping modulo 2^ADDR_WIDTH.
- Simultaneous events:
  - A write completing and a new request being accepted in the same cycle is legal; this gives back-to-back throughput of 1 word per cycle.
  - start while busy is ignored.
- reset mid-program: the pending write is dropped, mem_we drops on the next edge, and no done pulse is issued.

Decomposition:
- Shared package (isa_pkg):
  - opcode constants OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH;
  - format enum FMT_I, FMT_S, FMT_B, FMT_BAD;
  - FSM state encoding.
- One combinational sub-module, imm_pack: takes opcode and imm, outputs the format, the packed immediate bit positions and an illegal flag.
- The FSM, counters and output register stay in instr_encoder.

Test Plan:
- start, base_addr=0x100, length=1; request addi with rd=1, rs1=0, funct3=0, imm=5 -> one write at 0x100 with data 0x00500093, then done.
- length=3 with mem_ready held high: lw x2,-4(x1), then sw x2,8(x1), then beq x1,x2,+16 -> writes at 0x100, 0x104, 0x108 in consecutive cycles with data 0xFFC0A103, 0x0020A423, 0x00208863.
- mem_ready=0 for 3 cycles during a write -> mem_addr, mem_wdata and mem_we stay stable and in_ready=0; the write completes when mem_ready returns to 1.
- Illegal requests: addi with imm=2048, then beq with imm=3, then opcode 0110011 -> three err pulses, err_count=3, no writes, done still fires.
- Wrap: base_addr=0xFFFFFFFC, length=2 -> writes at 0xFFFFFFFC and then 0x00000000.
- reset asserted during DRAIN -> busy=0 and mem_we=0 next cycle, no done pulse; a following start runs normally.
